fifo_rd_burst_ctrl: RTL

//  Read-side consumer of the 128-bit async DMA FIFO (rd_clk domain). Waits for a full burst in the FIFO,

---
 rtl/fifo_rd_burst_pkg.sv | 21 ++
 rtl/fifo_rd_skid2.sv | 59 +++++
 rtl/fifo_rd_burst_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fifo_rd_burst_pkg.sv
// Shared types and defaults for the read-side FIFO burst controller.
// Optional partial-burst flush is enabled with `FIFO_RD_TIMEOUT_EN.
package fifo_rd_burst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int BURST_LEN_DEF = 16;
  localparam int TIMEOUT_DEF   = 256;
  localparam int BEAT_W        = $clog2(BURST_LEN_DEF + 1);
  localparam int TO_W          = $clog2(TIMEOUT_DEF);

  // Words already committed to the skid buffer once this cycle's drain is accounted for.
  function automatic logic [2:0] slots_used(input logic [1:0] occ, input logic inflight,
                                            input logic pop_out);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop_out};
  endfunction

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry ordered buffer that absorbs the FIFO read latency; head entry drives the stream.
module fifo_rd_skid2 #(
  parameter int W = 130
) (
  input  logic         rd_clk,
  input  logic         rd_rst,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   cnt;
  logic         pop;

  assign pop     = (cnt != 2'd0) && m_ready;
  assign m_valid = (cnt != 2'd0);
  assign m_data  = ent0;
  assign occ     = cnt;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({wr_valid, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            ent0 <= wr_data;
            cnt  <= 2'd1;
          end else if (cnt == 2'd1) begin
            ent1 <= wr_data;
            cnt  <= 2'd2;
          end
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word goes behind whatever remains.
          if (cnt == 2'd1) begin
            ent0 <= wr_data;
          end else begin
            ent0 <= ent1;
            ent1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_burst_ctrl.sv
// Pops whole bursts from the async DMA FIFO and streams them out with first/last tags.
// `FIFO_RD_TIMEOUT_EN adds an idle timeout that flushes a partial burst.
module fifo_rd_burst_ctrl
  import fifo_rd_burst_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int LVL_W     = 11,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic [LVL_W-1:0]  fifo_rd_water_level,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_first,
  output logic              m_last,
  output logic              busy,
  output logic              dbg_state
);

  localparam int BL_W = $clog2(BURST_LEN + 1);

  if (BURST_LEN < 1 || BURST_LEN > 2 ** (LVL_W - 1) || TIMEOUT < 2) begin : g_bad_cfg
    $error("fifo_rd_burst_ctrl: unsupported BURST_LEN/TIMEOUT");
  end

  state_t            state;
  logic [BL_W-1:0]   beats_left;
  logic              first_pend;
  logic              inflight;
  logic              infl_first;
  logic              infl_last;
  logic [1:0]        occ;
  logic              pop_out;
  logic              pop_acc;
  logic [2:0]        used;
  logic [DATA_W+1:0] skid_out;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] idle_cnt;
`endif

  assign pop_out    = m_valid && m_ready;
  assign used       = slots_used(occ, inflight, pop_out);
  assign fifo_rd_en = (state == BURST) && !fifo_rd_empty && (beats_left != '0) && (used < 3'd2);
  assign pop_acc    = fifo_rd_en && !fifo_rd_empty;

  assign busy      = (state != IDLE) || inflight || (occ != 2'd0);
  assign dbg_state = (state == BURST);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state      <= IDLE;
      beats_left <= '0;
      first_pend <= 1'b0;
      inflight   <= 1'b0;
      infl_first <= 1'b0;
      infl_last  <= 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
      idle_cnt   <= '0;
`endif
    end else begin
      // Tags are captured at pop time and ride alongside the word returned next cycle.
      inflight   <= pop_acc;
      infl_first <= pop_acc && first_pend;
      infl_last  <= pop_acc && (beats_left == BL_W'(1));
      case (state)
        IDLE: begin
          if (fifo_rd_water_level >= LVL_W'(BURST_LEN)) begin
            state      <= BURST;
            beats_left <= BL_W'(BURST_LEN);
            first_pend <= 1'b1;
`ifdef FIFO_RD_TIMEOUT_EN
            idle_cnt   <= '0;
          end else if (fifo_rd_water_level != '0) begin
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
              state      <= BURST;
              beats_left <= fifo_rd_water_level[BL_W-1:0];
              first_pend <= 1'b1;
              idle_cnt   <= '0;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end else begin
            idle_cnt <= '0;
`endif
          end
        end
        BURST: begin
          if (pop_acc) begin
            beats_left <= beats_left - BL_W'(1);
            first_pend <= 1'b0;
            if (beats_left == BL_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_rd_skid2 #(.W(DATA_W + 2)) u_skid (
    .rd_clk   (rd_clk),
    .rd_rst   (rd_rst),
    .wr_valid (inflight),
    .wr_data  ({infl_first, infl_last, fifo_rd_data}),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (skid_out),
    .occ      (occ)
  );

  assign m_first = skid_out[DATA_W+1];
  assign m_last  = skid_out[DATA_W];
  assign m_data  = skid_out[DATA_W-1:0];

endmodule
